// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle RV32I control unit: ula opcodes,
// RV32I major opcodes, FSM states and datapath mux select codes.
package controle_pkg;

  // ula operation codes (must match the ula encoding bit for bit)
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // RV32I major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // FSM states
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // ula A operand select
  localparam logic [1:0] SRC_A_RS1   = 2'd0;
  localparam logic [1:0] SRC_A_PC    = 2'd1;
  localparam logic [1:0] SRC_A_ZERO  = 2'd2;
  localparam logic [1:0] SRC_A_OLDPC = 2'd3;

  // ula B operand select
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_ALIGN  = 2'd2;

  // Writeback source select
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  // Branch condition from funct3 and the ula comparison flags
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       z,
                                        input logic       lt,
                                        input logic       ltu);
    logic t;
    t = 1'b0;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = !z;
      3'b100:  t = lt;
      3'b101:  t = !lt;
      3'b110:  t = ltu;
      3'b111:  t = !ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/controle_ula.sv
// Combinational instruction decode: opcode/funct3/funct7 to ula opcode,
// plus a flag for any encoding the control unit does not implement.
module controle_ula
  import controle_pkg::*;
#(
  parameter bit CHECK_FUNCT7 = 1'b1
) (
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [3:0] o_alu_op,
  output logic       o_illegal
);

  logic w_f7_zero;
  logic w_f7_alt;

  assign w_f7_zero = (i_funct7 == 7'b0000000);
  assign w_f7_alt  = (i_funct7 == 7'b0100000);

  // Per-class operation select and legality check
  always_comb begin
    o_alu_op  = ALU_ADD;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_REG: begin
        case (i_funct3)
          3'b000: o_alu_op = i_funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001: o_alu_op = ALU_SLL;
          3'b010: o_alu_op = ALU_SLT;
          3'b011: o_alu_op = ALU_SLTU;
          3'b100: o_alu_op = ALU_XOR;
          3'b101: o_alu_op = i_funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: o_alu_op = ALU_OR;
          default: o_alu_op = ALU_AND;
        endcase
        if (CHECK_FUNCT7) begin
          // 0100000 is only meaningful for SUB and SRA
          if (!(w_f7_zero ||
                (w_f7_alt && (i_funct3 == 3'b000 || i_funct3 == 3'b101))))
            o_illegal = 1'b1;
        end
      end
      OP_IMM: begin
        case (i_funct3)
          3'b000: o_alu_op = ALU_ADD;
          3'b001: begin
            o_alu_op = ALU_SLL;
            if (CHECK_FUNCT7 && !w_f7_zero) o_illegal = 1'b1;
          end
          3'b010: o_alu_op = ALU_SLT;
          3'b011: o_alu_op = ALU_SLTU;
          3'b100: o_alu_op = ALU_XOR;
          3'b101: begin
            o_alu_op = i_funct7[5] ? ALU_SRA : ALU_SRL;
            if (CHECK_FUNCT7 && !(w_f7_zero || w_f7_alt)) o_illegal = 1'b1;
          end
          3'b110: o_alu_op = ALU_OR;
          default: o_alu_op = ALU_AND;
        endcase
      end
      OP_LUI, OP_AUIPC, OP_JAL: o_alu_op = ALU_ADD;
      OP_JALR: begin
        o_alu_op = ALU_ADD;
        if (i_funct3 != 3'b000) o_illegal = 1'b1;
      end
      OP_LOAD: begin
        o_alu_op = ALU_ADD;
        if (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111)
          o_illegal = 1'b1;
      end
      OP_STORE: begin
        o_alu_op = ALU_ADD;
        if (i_funct3 > 3'b010) o_illegal = 1'b1;
      end
      OP_BRANCH: begin
        o_alu_op = ALU_SUB;
        if (i_funct3 == 3'b010 || i_funct3 == 3'b011) o_illegal = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle RV32I control unit. Sequences FETCH/DECODE/EXEC/MEM/WB and
// drives the ula opcode plus all datapath selects and strobes. Outputs are
// combinational from state, instr, ula flags and mem_ready.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter logic [2:0] RESET_STATE  = 3'd0,
  parameter bit         CHECK_FUNCT7 = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        less,
  input  logic        less_unsigned,
  input  logic        mem_ready,
  output logic [3:0]  ALU_operacao,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal
);

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [3:0] w_dec_op;
  logic       w_dec_illegal;
  logic       w_is_load;
  logic       w_unused_instr;

  assign w_opcode       = instr[6:0];
  assign w_funct3       = instr[14:12];
  assign w_funct7       = instr[31:25];
  assign w_is_load      = (w_opcode == OP_LOAD);
  assign w_unused_instr = ^{instr[24:15], instr[11:7]};

  controle_ula #(
    .CHECK_FUNCT7(CHECK_FUNCT7)
  ) u_ula_dec (
    .i_opcode (w_opcode),
    .i_funct3 (w_funct3),
    .i_funct7 (w_funct7),
    .o_alu_op (w_dec_op),
    .o_illegal(w_dec_illegal)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= state_t'(RESET_STATE);
    else       r_state <= w_next;
  end

  // Sticky illegal flag, set on the DECODE -> TRAP transition
  always_ff @(posedge clk) begin
    if (reset)                                          r_illegal <= 1'b0;
    else if (r_state == ST_DECODE && w_dec_illegal)     r_illegal <= 1'b1;
    else if (r_state == ST_TRAP)                        r_illegal <= 1'b1;
  end

  assign illegal = r_illegal;

  // Next-state and datapath control
  always_comb begin
    w_next       = r_state;
    ALU_operacao = ALU_ADD;
    alu_src_a    = SRC_A_RS1;
    alu_src_b    = SRC_B_RS2;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_ALU;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = WB_ALUOUT;
    case (r_state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        w_next    = w_dec_illegal ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        ALU_operacao = w_dec_op;
        case (w_opcode)
          OP_REG: w_next = ST_WB;
          OP_IMM: begin
            alu_src_b = SRC_B_IMM;
            w_next    = ST_WB;
          end
          OP_LUI: begin
            alu_src_a = SRC_A_ZERO;
            alu_src_b = SRC_B_IMM;
            w_next    = ST_WB;
          end
          OP_AUIPC: begin
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_IMM;
            w_next    = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b = SRC_B_IMM;
            w_next    = ST_MEM;
          end
          OP_BRANCH: begin
            if (branch_taken(w_funct3, zero, less, less_unsigned)) begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_ALUOUT;
            end
            w_next = ST_FETCH;
          end
          OP_JAL: begin
            pc_write  = 1'b1;
            pc_src    = PC_SRC_ALUOUT;
            reg_write = 1'b1;
            wb_sel    = WB_PC4;
            w_next    = ST_FETCH;
          end
          OP_JALR: begin
            alu_src_b = SRC_B_IMM;
            pc_write  = 1'b1;
            pc_src    = PC_SRC_ALIGN;
            reg_write = 1'b1;
            wb_sel    = WB_PC4;
            w_next    = ST_FETCH;
          end
          default: w_next = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        iord = 1'b1;
        if (w_is_load) mem_read  = 1'b1;
        else           mem_write = 1'b1;
        if (mem_ready) w_next = w_is_load ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = w_is_load ? WB_MDR : WB_ALUOUT;
        w_next    = ST_FETCH;
      end
      ST_TRAP: w_next = ST_TRAP;
      default: w_next = ST_FETCH;
    endcase
    // Reset silences every strobe and select in the same cycle
    if (reset) begin
      ALU_operacao = ALU_ADD;
      alu_src_a    = '0;
      alu_src_b    = '0;
      pc_write     = 1'b0;
      pc_src       = '0;
      ir_write     = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      iord         = 1'b0;
      reg_write    = 1'b0;
      wb_sel       = '0;
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: steps instruction sequences one
// cycle at a time and compares the packed control word each cycle.
module tb_controle_multiciclo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero, less, less_unsigned, mem_ready;
  logic [3:0]  ALU_operacao;
  logic [1:0]  alu_src_a, alu_src_b, pc_src, wb_sel;
  logic        pc_write, ir_write, mem_read, mem_write, iord, reg_write;
  logic        illegal;
  logic [17:0] w_obs;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        exp_ill  = 1'b0;

  always #5 clk = ~clk;

  controle_multiciclo #(
    .RESET_STATE (3'd0),
    .CHECK_FUNCT7(1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .zero         (zero),
    .less         (less),
    .less_unsigned(less_unsigned),
    .mem_ready    (mem_ready),
    .ALU_operacao (ALU_operacao),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .ir_write     (ir_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .iord         (iord),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .illegal      (illegal)
  );

  assign w_obs = {ALU_operacao, alu_src_a, alu_src_b, pc_write, pc_src,
                  ir_write, mem_read, mem_write, iord, reg_write, wb_sel};

  // Control word: op, A, B, pc_write, pc_src, ir_write, mem_read,
  // mem_write, iord, reg_write, wb_sel
  function automatic logic [17:0] cw(input logic [3:0] op, input logic [1:0] a,
                                     input logic [1:0] b, input logic pcw,
                                     input logic [1:0] pcs, input logic irw,
                                     input logic mr, input logic mw,
                                     input logic io, input logic rw,
                                     input logic [1:0] wb);
    return {op, a, b, pcw, pcs, irw, mr, mw, io, rw, wb};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: compare control word and illegal, then advance
  task automatic cyc(input string tag, input logic [17:0] exp);
    #2;
    check(tag, {14'b0, w_obs}, {14'b0, exp});
    check({tag, ".ill"}, {31'b0, illegal}, {31'b0, exp_ill});
    @(posedge clk);
    #1;
  endtask

  logic [17:0] F_RDY, F_WAIT, DEC, NONE, WB_ALU, WB_LD, MEM_LD, MEM_ST, EX_IMM;

  initial begin
    F_RDY  = cw(4'd0, 2'd1, 2'd2, 1, 2'd0, 1, 1, 0, 0, 0, 2'd0);
    F_WAIT = cw(4'd0, 2'd1, 2'd2, 0, 2'd0, 0, 1, 0, 0, 0, 2'd0);
    DEC    = cw(4'd0, 2'd3, 2'd1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0);
    NONE   = '0;
    WB_ALU = cw(4'd0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 1, 2'd0);
    WB_LD  = cw(4'd0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 1, 2'd1);
    MEM_LD = cw(4'd0, 2'd0, 2'd0, 0, 2'd0, 0, 1, 0, 1, 0, 2'd0);
    MEM_ST = cw(4'd0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 1, 1, 0, 2'd0);
    EX_IMM = cw(4'd0, 2'd0, 2'd1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0);

    reset = 1'b1; instr = '0; zero = 0; less = 0; less_unsigned = 0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("reset", NONE);
    reset = 1'b0;

    // ALU class: F D E W, back in FETCH on cycle 5
    instr = 32'h002081B3;
    cyc("add.F", F_RDY); cyc("add.D", DEC); cyc("add.E", NONE);
    cyc("add.W", WB_ALU);
    instr = 32'h402081B3;
    cyc("sub.F", F_RDY); cyc("sub.D", DEC);
    cyc("sub.E", cw(4'd1, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0));
    cyc("sub.W", WB_ALU);
    instr = 32'h4020D193;
    cyc("srai.F", F_RDY); cyc("srai.D", DEC);
    cyc("srai.E", cw(4'd7, 2'd0, 2'd1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0));
    cyc("srai.W", WB_ALU);
    instr = 32'h0020B193;
    cyc("sltiu.F", F_RDY); cyc("sltiu.D", DEC);
    cyc("sltiu.E", cw(4'd9, 2'd0, 2'd1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0));
    cyc("sltiu.W", WB_ALU);
    instr = 32'h123450B7;
    cyc("lui.F", F_RDY); cyc("lui.D", DEC);
    cyc("lui.E", cw(4'd0, 2'd2, 2'd1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0));
    cyc("lui.W", WB_ALU);
    instr = 32'h00001097;
    cyc("auipc.F", F_RDY); cyc("auipc.D", DEC);
    cyc("auipc.E", cw(4'd0, 2'd3, 2'd1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0));
    cyc("auipc.W", WB_ALU);

    // Branches: 3 cycles each
    instr = 32'h00208063; zero = 1'b1;
    cyc("beq.F", F_RDY); cyc("beq.D", DEC);
    cyc("beq.E", cw(4'd1, 2'd0, 2'd0, 1, 2'd1, 0, 0, 0, 0, 0, 2'd0));
    instr = 32'h0020E063; zero = 1'b0; less_unsigned = 1'b0;
    cyc("bltu.F", F_RDY); cyc("bltu.D", DEC);
    cyc("bltu.E", cw(4'd1, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0));
    instr = 32'h0020D063; less = 1'b0;
    cyc("bge.F", F_RDY); cyc("bge.D", DEC);
    cyc("bge.E", cw(4'd1, 2'd0, 2'd0, 1, 2'd1, 0, 0, 0, 0, 0, 2'd0));

    // Jumps
    instr = 32'h008000EF;
    cyc("jal.F", F_RDY); cyc("jal.D", DEC);
    cyc("jal.E", cw(4'd0, 2'd0, 2'd0, 1, 2'd1, 0, 0, 0, 0, 1, 2'd2));
    instr = 32'h000080E7;
    cyc("jalr.F", F_RDY); cyc("jalr.D", DEC);
    cyc("jalr.E", cw(4'd0, 2'd0, 2'd1, 1, 2'd2, 0, 0, 0, 0, 1, 2'd2));

    // Load with 2 FETCH waits and 3 MEM waits: 10 cycles
    instr = 32'h0000A183; mem_ready = 1'b0;
    cyc("lw.Fw0", F_WAIT); cyc("lw.Fw1", F_WAIT);
    mem_ready = 1'b1;
    cyc("lw.F", F_RDY); cyc("lw.D", DEC); cyc("lw.E", EX_IMM);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw.Mw", MEM_LD);
    mem_ready = 1'b1;
    cyc("lw.M", MEM_LD); cyc("lw.W", WB_LD);

    // Store: 4 cycles
    instr = 32'h0020A023;
    cyc("sw.F", F_RDY); cyc("sw.D", DEC); cyc("sw.E", EX_IMM);
    cyc("sw.M", MEM_ST);

    // Unknown opcode: TRAP, sticky illegal, no strobes
    instr = 32'h0000007F;
    cyc("trap.F", F_RDY); cyc("trap.D", DEC);
    exp_ill = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      cyc("trap.hold", NONE);
    end
    mem_ready = 1'b1;
    reset = 1'b1;
    cyc("trap.rst", NONE);
    reset = 1'b0; exp_ill = 1'b0;

    // Reset in the MEM wait of a store abandons it
    instr = 32'h0020A023;
    cyc("swr.F", F_RDY); cyc("swr.D", DEC); cyc("swr.E", EX_IMM);
    mem_ready = 1'b0;
    cyc("swr.Mw", MEM_ST);
    reset = 1'b1;
    cyc("swr.rst", NONE);
    reset = 1'b0; mem_ready = 1'b1;

    // R-type funct7 outside 0000000/0100000 is illegal
    instr = 32'h022081B3;
    cyc("f7.F", F_RDY); cyc("f7.D", DEC);
    exp_ill = 1'b1;
    cyc("f7.T0", NONE); cyc("f7.T1", NONE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Multicycle RV32I control unit: the driving end of the ula interface.
- Sequences fetch/decode/execute/memory/writeback and produces ALU_operacao and the datapath mux/strobe signals.
- Consumes zero/less/less_unsigned to resolve branches.
- Sits beside the datapath that holds PC, old_pc, IR, the register file, alu_out and mdr; handshakes with a single instruction/data memory port.

Parameters:
- RESET_STATE, 3'd0 (FETCH), state entered on reset
- CHECK_FUNCT7, 1, when 1 any R-type funct7 other than 0000000/0100000 (0100000 legal only for SUB/SRA) is illegal

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instr  in  32  current IR contents, valid from DECODE onward
- zero  in  1  ula result==0
- less  in  1  ula signed A<B
- less_unsigned  in  1  ula unsigned A<B
- mem_ready  in  1  memory completes the current read/write this cycle
- ALU_operacao  out  4  ula opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU
- alu_src_a  out  2  ula A select: 0 rs1, 1 PC, 2 zero, 3 old_pc
- alu_src_b  out  2  ula B select: 0 rs2, 1 imm, 2 const 4
- pc_write  out  1  load PC this cycle
- pc_src  out  2  PC source: 0 ula result, 1 alu_out register, 2 ula result with bit0 cleared
- ir_write  out  1  latch IR and old_pc<=PC
- mem_read  out  1  memory read request; address is PC in FETCH, alu_out in MEM
- mem_write  out  1  memory write request
- iord  out  1  memory address select: 0 PC, 1 alu_out
- reg_write  out  1  register-file write strobe
- wb_sel  out  2  writeback source: 0 alu_out, 1 mdr, 2 old_pc+4
- illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Reset:
  - state<=FETCH, illegal<=0.
  - While reset is high, every strobe (pc_write, ir_write, mem_read, mem_write, reg_write) is 0, all selects are 0 and ALU_operacao=0000.
  - Reset mid-operation abandons the instruction with no write; FETCH follows the release cycle.
- Outputs are combinational from state, instr, flags and mem_ready. The only sequential elements are the state register and illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - Drives mem_read=1, iord=0.
  - Holds until mem_ready. In the mem_ready cycle it also drives ir_write=1, pc_write=1, pc_src=0, A=PC, B=4, ADD, then goes to DECODE.
- DECODE:
  - Computes ADD with A=old_pc, B=imm; the datapath captures alu_out (branch/JAL target).
  - Unknown opcode, or illegal funct3/funct7 -> TRAP.
- EXEC, by class:
  - R-type: A=rs1, B=rs2; op from funct3/funct7 -> WB.
  - I-ALU: B=imm; SRAI from funct7 bit5; SUB is never produced from I-type -> WB.
  - LUI: A=zero, B=imm, ADD -> WB.
  - AUIPC: A=old_pc, B=imm, ADD -> WB.
  - LOAD/STORE: A=rs1, B=imm, ADD -> MEM.
  - BRANCH:
    - A=rs1, B=rs2, SUB.
    - Taken per funct3: BEQ zero, BNE !zero, BLT less, BGE !less, BLTU less_unsigned, BGEU !less_unsigned.
    - If taken: pc_write=1, pc_src=1.
    - Next state FETCH.
  - JAL: pc_write=1, pc_src=1, reg_write=1, wb_sel=2 -> FETCH.
  - JALR: A=rs1, B=imm, ADD, pc_write=1, pc_src=2, reg_write=1, wb_sel=2 -> FETCH.
- MEM:
  - iord=1; mem_read (load) or mem_write (store) held until mem_ready.
  - Store -> FETCH on mem_ready; load -> WB on mem_ready.
- WB: reg_write=1; wb_sel=1 for load, else 0 -> FETCH.
- TRAP: illegal=1 sticky, all strobes 0, stays until reset.
- Latency with mem_ready tied high:
  - branch/JAL/JALR: 3 cycles
  - store: 4 cycles
  - ALU/LUI/AUIPC: 4 cycles
  - load: 5 cycles
- Each wait cycle on mem_ready adds exactly one cycle. Strobes remain stable during waits.
- Never in the same cycle: pc_write with mem_write; ir_write outside FETCH.

Decomposition:
- Package controle_pkg holds:
  - ALU op constants, identical to the ula encoding
  - RV32I opcode constants
  - state encoding
  - alu_src_a/alu_src_b/pc_src/wb_sel codes
- One sub-module, controle_ula: combinational opcode/funct3/funct7 -> ALU_operacao plus an illegal-decode bit, instantiated for EXEC.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH,DECODE,EXEC(op 0000, A=0, B=0),WB(reg_write=1, wb_sel=0), back in FETCH on cycle 5.
- SUB (0x402081B3) -> op 0001; SRAI (0x4020D193) -> op 0111, alu_src_b=1; SLTIU (0x0020B193) -> op 1001.
- BEQ with zero=1 in EXEC -> pc_write=1, pc_src=1; BLTU with less_unsigned=0 -> pc_write=0; both return to FETCH after 3 cycles.
- LW with mem_ready low for 2 cycles in FETCH and 3 in MEM -> mem_read held throughout with iord 0 then 1, reg_write=1 wb_sel=1 in WB; total 10 cycles.
- JALR (0x000080E7) -> EXEC asserts pc_write, pc_src=2, reg_write, wb_sel=2 simultaneously.
- Opcode 0x0000007F -> TRAP after DECODE, illegal=1, no strobes for 20 cycles; reset asserted in MEM of a store -> mem_write drops in the reset cycle, state returns to FETCH and illegal clears.
